// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, types and code helpers for the viterbi_txrx
// loopback link (rate-1/2, K=3 convolutional code with a Viterbi decoder).
package viterbi_pkg;

  localparam int K          = 3;
  localparam logic [2:0] G0 = 3'o7;
  localparam logic [2:0] G1 = 3'o5;
  localparam int NUM_STATES = 4;
  localparam int METRIC_W   = 6;

  localparam int LATENCY    = 4105;
  localparam int TB_DEPTH   = 32;
  localparam int ERR_PERIOD = 16;

  // The survivor memory accounts for TB_DEPTH cycles of latency; the delay
  // line makes up the rest so a bit emerges exactly LATENCY edges later.
  localparam int DELAY_LEN  = LATENCY - TB_DEPTH;

  // Fibonacci LFSR, taps 16,14,13,11 mapped to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [1:0]          sym_t;

  localparam metric_t METRIC_MAX = '1;

  // Code symbol {c1,c0} for the shift register contents {d, s1, s0}.
  function automatic sym_t conv_sym(input logic [2:0] regs);
    return {^(regs & G1), ^(regs & G0)};
  endfunction

  // Hamming distance between an expected and a received symbol (0..2).
  function automatic logic [1:0] branch_metric(input sym_t a, input sym_t b);
    sym_t x;
    x = a ^ b;
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

endpackage

// File: rtl/viterbi_txrx_if.sv
// viterbi_txrx_if: source-bit / decoded-bit bundle of the loopback link.
// The master side supplies data and enable, the slave side returns decoded bits.
interface viterbi_txrx_if;
  logic encoder_i;
  logic enable_encoder_i;
  logic decoder_o;

  modport master (output encoder_i, output enable_encoder_i, input decoder_o);
  modport slave  (input encoder_i, input enable_encoder_i, output decoder_o);
endinterface

// File: rtl/viterbi_acs.sv
// viterbi_acs: one add-compare-select cell of the 4-state Viterbi decoder.
// Sums are formed one bit wider so an unreachable (63) predecessor cannot wrap;
// the result saturates at the metric maximum before normalisation in the top.
module viterbi_acs
  import viterbi_pkg::*;
(
  input  metric_t    pm0_i,
  input  metric_t    pm1_i,
  input  logic [1:0] bm0_i,
  input  logic [1:0] bm1_i,
  output metric_t    pm_o,
  output logic       dec_o
);

  logic [METRIC_W:0] sum0;
  logic [METRIC_W:0] sum1;
  logic [METRIC_W:0] sel;

  // Add both candidates, keep the smaller one; ties favour predecessor 0.
  always_comb begin
    sum0  = {1'b0, pm0_i} + {{(METRIC_W-1){1'b0}}, bm0_i};
    sum1  = {1'b0, pm1_i} + {{(METRIC_W-1){1'b0}}, bm1_i};
    dec_o = (sum1 < sum0);
    sel   = dec_o ? sum1 : sum0;
    pm_o  = (sel > {1'b0, METRIC_MAX}) ? METRIC_MAX : sel[METRIC_W-1:0];
  end

endmodule

// File: rtl/viterbi_txrx.sv
// viterbi_txrx: convolutional encoder -> hard-decision channel -> Viterbi
// decoder (register exchange) -> latency-padding delay line.
// Optional feature macro: VITERBI_ERR_INJ_EN enables LFSR-driven channel
// error injection; without it the channel is transparent.
module viterbi_txrx
  import viterbi_pkg::*;
(
  input logic           clk,
  input logic           rst,
  viterbi_txrx_if.slave bus
);

  // Status visible to the bench by hierarchy.
  sym_t        err_inj;
  logic [15:0] bad_bit_ct;
  logic [15:0] word_ct;

  logic        data_bit;
  logic [1:0]  enc_state_q;
  sym_t        sym_q;
  sym_t        rx;

  metric_t                 pm_q   [NUM_STATES];
  metric_t                 pm_d   [NUM_STATES];
  metric_t                 acs_pm [NUM_STATES];
  metric_t                 pm_min;
  logic [NUM_STATES-1:0]   acs_dec;
  logic [TB_DEPTH-1:0]     surv_q [NUM_STATES];
  logic [TB_DEPTH-1:0]     surv_d [NUM_STATES];
  logic [1:0]              best_state;
  logic                    oldest_bit;
  logic [DELAY_LEN-1:0]    dly_q;

  assign data_bit = bus.encoder_i & bus.enable_encoder_i;

  // Encoder: register the code symbol and shift the new bit into the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_q <= '0;
      sym_q       <= '0;
    end else begin
      sym_q       <= conv_sym({data_bit, enc_state_q});
      enc_state_q <= {data_bit, enc_state_q[1]};
    end
  end

`ifdef VITERBI_ERR_INJ_EN
  logic [15:0] lfsr_q;

  // Flip one symbol bit in the last cycle of each error period.
  always_comb begin
    err_inj = '0;
    if (word_ct[3:0] == 4'(ERR_PERIOD - 1)) begin
      err_inj = lfsr_q[0] ? 2'b10 : 2'b01;
    end
  end

  // LFSR free-runs every cycle to pick which symbol bit gets corrupted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end
`else
  assign err_inj = '0;
`endif

  assign rx = sym_q ^ err_inj;

  // Cycle counter and saturating count of corrupted channel bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_ct    <= '0;
      bad_bit_ct <= '0;
    end else begin
      word_ct <= word_ct + 16'd1;
      if ((err_inj != '0) && (bad_bit_ct != 16'hFFFF)) begin
        bad_bit_ct <= bad_bit_ct + 16'd1;
      end
    end
  end

  // New state {n1,n0} is reached from {n0,0} and {n0,1} with input bit n1.
  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam logic [1:0] NS = 2'(n);
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branch_metric(conv_sym({NS, 1'b0}), rx);
    assign bm1 = branch_metric(conv_sym({NS, 1'b1}), rx);

    viterbi_acs u_acs (
      .pm0_i (pm_q[{NS[0], 1'b0}]),
      .pm1_i (pm_q[{NS[0], 1'b1}]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (acs_pm[n]),
      .dec_o (acs_dec[n])
    );
  end

  // Normalise metrics against the minimum and extend the chosen survivors.
  always_comb begin
    pm_min = acs_pm[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (acs_pm[s] < pm_min) pm_min = acs_pm[s];
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_d[s]   = acs_pm[s] - pm_min;
      surv_d[s] = {surv_q[{s[0], acs_dec[s]}][TB_DEPTH-2:0], s[1]};
    end
  end

  // Path metrics and survivor registers; state 0 starts as the only likely one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? metric_t'(0) : METRIC_MAX;
        surv_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= pm_d[s];
        surv_q[s] <= surv_d[s];
      end
    end
  end

  // Oldest bit of the lowest-metric survivor; ties go to the lowest index.
  always_comb begin
    best_state = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_q[s] < pm_q[best_state]) best_state = 2'(s);
    end
    oldest_bit = surv_q[best_state][TB_DEPTH-1];
  end

  // Delay line pads the decoder output to the fixed end-to-end latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0;
    end else begin
      dly_q <= {dly_q[DELAY_LEN-2:0], oldest_bit};
    end
  end

  assign bus.decoder_o = dly_q[DELAY_LEN-1];

endmodule

// File: tb/tb_viterbi_txrx.sv
// tb_viterbi_txrx: directed self-checking bench for the viterbi_txrx link.
// Every sampled source bit is logged; decoder_o is compared against the bit
// logged LATENCY edges earlier, and the status counters against closed forms.
module tb_viterbi_txrx;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  viterbi_txrx_if bus ();

  viterbi_txrx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic hist [0:32767];

  // Drive one bit, take the rising edge, log the effective bit, settle 1 ns.
  task automatic applyStimulus(input logic bit_v, input logic en_v);
    bus.encoder_i        = bit_v;
    bus.enable_encoder_i = en_v;
    @(posedge clk);
    hist[cyc] = bit_v & en_v;
    cyc++;
    #1;
  endtask

  // Bit expected on decoder_o after edge cyc-1.
  function automatic logic expectedOut();
    if (cyc > LATENCY) return hist[cyc - 1 - LATENCY];
    return 1'b0;
  endfunction

  function automatic logic [15:0] expectedBad();
`ifdef VITERBI_ERR_INJ_EN
    return 16'(cyc / 16);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic errMaskOk(input logic [1:0] m);
`ifdef VITERBI_ERR_INJ_EN
    if ((cyc % 16) == 15) return (m == 2'b01) || (m == 2'b10);
    return m == 2'b00;
`else
    return m == 2'b00;
`endif
  endfunction

  task automatic test_reset();
    bus.encoder_i        = 1'b1;
    bus.enable_encoder_i = 1'b1;
    rst = 1'b0;
    #1000;
    checks++;
    if (bus.decoder_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out got=%0b exp=0", bus.decoder_o);
    end
    checks++;
    if (dut.word_ct !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_word_ct got=%0d exp=0", dut.word_ct);
    end
    checks++;
    if (dut.bad_bit_ct !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_bad_bit_ct got=%0d exp=0", dut.bad_bit_ct);
    end
    checks++;
    if (dut.err_inj !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_err_inj got=%b exp=00", dut.err_inj);
    end
    bus.encoder_i = 1'b0;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_zero_stream();
    for (int i = 0; i < 4200; i++) begin
      applyStimulus(1'b0, 1'b1);
      checks++;
      if (bus.decoder_o !== 1'b0) begin
        errors++; $display("[TB] FAIL zero_out cyc=%0d got=%0b exp=0", cyc, bus.decoder_o);
      end
      checks++;
      if (dut.bad_bit_ct !== expectedBad()) begin
        errors++; $display("[TB] FAIL zero_bad_bit_ct cyc=%0d got=%0d exp=%0d", cyc, dut.bad_bit_ct, expectedBad());
      end
      checks++;
      if (dut.word_ct !== cyc[15:0]) begin
        errors++; $display("[TB] FAIL zero_word_ct cyc=%0d got=%0d exp=%0d", cyc, dut.word_ct, cyc[15:0]);
      end
      checks++;
      if (!errMaskOk(dut.err_inj)) begin
        errors++; $display("[TB] FAIL zero_err_inj cyc=%0d got=%b exp=%s", cyc, dut.err_inj, ((cyc % 16) == 15) ? "onehot_or_00" : "00");
      end
    end
  endtask

  task automatic test_patterns();
    logic b;
    for (int rep = 0; rep < 2; rep++) begin
      for (int len = 1; len <= 5; len++) begin
        for (int k = 0; k < 2 * len; k++) begin
          b = (k < len);
          applyStimulus(b, 1'b1);
          checks++;
          if (bus.decoder_o !== expectedOut()) begin
            errors++; $display("[TB] FAIL pattern_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
          end
        end
      end
      for (int k = 0; k < 98; k++) begin
        b = ((k % 2) == 0);
        applyStimulus(b, 1'b1);
        checks++;
        if (bus.decoder_o !== expectedOut()) begin
          errors++; $display("[TB] FAIL alt_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
        end
      end
    end
  endtask

  task automatic test_random_runs();
    logic [19:0] rnd;
    logic        b;
    rnd = 20'hB2E59;
    for (int i = 0; i < 220; i++) begin
      if (i < 20)       b = rnd[19 - i];
      else if (i < 120) b = 1'b1;
      else              b = 1'b0;
      applyStimulus(b, 1'b1);
      checks++;
      if (bus.decoder_o !== expectedOut()) begin
        errors++; $display("[TB] FAIL runs_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
      end
      checks++;
      if (dut.bad_bit_ct !== expectedBad()) begin
        errors++; $display("[TB] FAIL runs_bad_bit_ct cyc=%0d got=%0d exp=%0d", cyc, dut.bad_bit_ct, expectedBad());
      end
      checks++;
      if (dut.word_ct !== cyc[15:0]) begin
        errors++; $display("[TB] FAIL runs_word_ct cyc=%0d got=%0d exp=%0d", cyc, dut.word_ct, cyc[15:0]);
      end
    end
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b0);
      checks++;
      if (bus.decoder_o !== expectedOut()) begin
        errors++; $display("[TB] FAIL enlow_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
      end
    end
  endtask

  // All-ones tail flushes every earlier bit through the full latency.
  task automatic test_drain();
    for (int i = 0; i < 4110; i++) begin
      applyStimulus(1'b1, 1'b1);
      checks++;
      if (bus.decoder_o !== expectedOut()) begin
        errors++; $display("[TB] FAIL drain_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
      end
      checks++;
      if (dut.bad_bit_ct !== expectedBad()) begin
        errors++; $display("[TB] FAIL drain_bad_bit_ct cyc=%0d got=%0d exp=%0d", cyc, dut.bad_bit_ct, expectedBad());
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] head;
    logic       b;
    head = 7'b1001101;
    checks++;
    if (bus.decoder_o !== 1'b1) begin
      errors++; $display("[TB] FAIL prereset_out got=%0b exp=1", bus.decoder_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.decoder_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_out got=%0b exp=0", bus.decoder_o);
    end
    checks++;
    if (dut.word_ct !== 16'd0) begin
      errors++; $display("[TB] FAIL midreset_word_ct got=%0d exp=0", dut.word_ct);
    end
    checks++;
    if (dut.bad_bit_ct !== 16'd0) begin
      errors++; $display("[TB] FAIL midreset_bad_bit_ct got=%0d exp=0", dut.bad_bit_ct);
    end
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < LATENCY + 20; i++) begin
      b = (i < 7) ? head[6 - i] : 1'b0;
      applyStimulus(b, 1'b1);
      checks++;
      if (bus.decoder_o !== expectedOut()) begin
        errors++; $display("[TB] FAIL relaunch_out cyc=%0d got=%0b exp=%0b", cyc, bus.decoder_o, expectedOut());
      end
      checks++;
      if (dut.word_ct !== cyc[15:0]) begin
        errors++; $display("[TB] FAIL relaunch_word_ct cyc=%0d got=%0d exp=%0d", cyc, dut.word_ct, cyc[15:0]);
      end
      if (cyc == LATENCY + 1) begin
        checks++;
        if (bus.decoder_o !== 1'b1) begin
          errors++; $display("[TB] FAIL relaunch_first_bit got=%0b exp=1", bus.decoder_o);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] viterbi_txrx bench start, LATENCY=%0d", LATENCY);
    test_reset();
    test_zero_stream();
    test_patterns();
    test_random_runs();
    test_enable_low();
    test_drain();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
